// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the two-master AXI read arbiter.
// Holds the FSM state encoding, the AXI ID values for each master and the fixed AR attributes.
// Define ARB_ROUND_ROBIN_EN to make ties alternate instead of favouring the dcache.
package axi_rd_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_ADDR = 2'd1,
      ARB_DATA = 2'd2
   } arb_state_t;

   localparam logic [3:0] ARB_ID_S0      = 4'd0;
   localparam logic [3:0] ARB_ID_S1      = 4'd1;
   localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   // AXI ID that is driven for a grant to master 0 (sel=0) or master 1 (sel=1)
   function automatic logic [3:0] arb_id(input logic sel);
      return sel ? ARB_ID_S1 : ARB_ID_S0;
   endfunction

endpackage

// File: rtl/axi_rd_arbiter_pick2.sv
// Two-way request picker: pick=0 selects s0 (icache), pick=1 selects s1 (dcache).
// Combinational pick; with ARB_ROUND_ROBIN_EN a last_grant register alternates ties.
// Without ARB_ROUND_ROBIN_EN the dcache wins every tie and no state is kept.
module axi_rd_arbiter_pick2 (
`ifdef ARB_ROUND_ROBIN_EN
   input  logic clk,
   input  logic rst,
   input  logic take,
`endif
   input  logic req0,
   input  logic req1,
   output logic pick
);

`ifdef ARB_ROUND_ROBIN_EN
   // last_grant resets to s1 so the icache wins the first tie
   logic last_grant;

   // on a tie hand the port to whoever did not have it last
   always_comb begin
      pick = req1;
      if (req0 && req1) pick = ~last_grant;
   end

   // remember the master granted on each accepted request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      last_grant <= 1'b1;
      else if (take) last_grant <= pick;
   end
`else
   // fixed priority: dcache refills are latency critical, so s1 wins ties
   always_comb begin
      pick = req1 ? 1'b1 : 1'b0;
      if (!req1 && req0) pick = 1'b0;
   end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read port between icache (s0) and dcache (s1), one burst outstanding at a time.
// Grant visible one cycle after request; one IDLE bubble after the last beat before the next grant.
// Loser's request waits (no arready); R beats are passed only to the owner. Option: ARB_ROUND_ROBIN_EN.
module axi_rd_arbiter
   import axi_rd_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] s0_araddr,
   input  logic [LEN_W-1:0]  s0_arlen,
   input  logic              s0_arvalid,
   output logic              s0_arready,
   output logic              s0_rvalid,
   output logic              s0_rlast,
   input  logic [ADDR_W-1:0] s1_araddr,
   input  logic [LEN_W-1:0]  s1_arlen,
   input  logic              s1_arvalid,
   output logic              s1_arready,
   output logic              s1_rvalid,
   output logic              s1_rlast,
   output logic [DATA_W-1:0] s_rdata,
   output logic [3:0]        m_arid,
   output logic [ADDR_W-1:0] m_araddr,
   output logic [LEN_W-1:0]  m_arlen,
   output logic [2:0]        m_arsize,
   output logic [1:0]        m_arburst,
   output logic              m_arvalid,
   input  logic              m_arready,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_rvalid,
   input  logic              m_rlast,
   output logic              m_rready
);

   arb_state_t state;
   logic       owner;
   logic       pick;
   logic       in_data;

`ifdef ARB_ROUND_ROBIN_EN
   logic take;
   assign take = (state == ARB_IDLE) && (s0_arvalid || s1_arvalid);
`endif

   axi_rd_arbiter_pick2 u_pick (
`ifdef ARB_ROUND_ROBIN_EN
      .clk  (clk),
      .rst  (rst),
      .take (take),
`endif
      .req0 (s0_arvalid),
      .req1 (s1_arvalid),
      .pick (pick)
   );

   // word-sized incrementing bursts only
   assign m_arsize  = AXI_SIZE_WORD;
   assign m_arburst = AXI_BURST_INCR;

   // read channel is only open while a burst is in flight; beats go to the owner alone
   assign in_data    = (state == ARB_DATA);
   assign m_rready   = in_data;
   assign s_rdata    = m_rdata;
   assign s0_rvalid  = in_data && !owner && m_rvalid;
   assign s0_rlast   = in_data && !owner && m_rvalid && m_rlast;
   assign s1_rvalid  = in_data &&  owner && m_rvalid;
   assign s1_rlast   = in_data &&  owner && m_rvalid && m_rlast;

   // arbitration FSM: grant, hold AR until accepted, wait for the last beat
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ARB_IDLE;
         owner      <= 1'b0;
         m_arvalid  <= 1'b0;
         m_araddr   <= '0;
         m_arlen    <= '0;
         m_arid     <= ARB_ID_S0;
         s0_arready <= 1'b0;
         s1_arready <= 1'b0;
      end else begin
         s0_arready <= 1'b0;
         s1_arready <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (s0_arvalid || s1_arvalid) begin
                  owner      <= pick;
                  m_arid     <= arb_id(pick);
                  m_araddr   <= pick ? s1_araddr : s0_araddr;
                  m_arlen    <= pick ? s1_arlen  : s0_arlen;
                  m_arvalid  <= 1'b1;
                  s0_arready <= !pick;
                  s1_arready <= pick;
                  state      <= ARB_ADDR;
               end
            end
            ARB_ADDR: begin
               if (m_arready) begin
                  m_arvalid <= 1'b0;
                  state     <= ARB_DATA;
               end
            end
            ARB_DATA: begin
               // arlen is not counted; the slave's rlast closes the burst
               if (m_rvalid && m_rlast) state <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter with hand-computed expectations.
// Inputs driven 1 ns after the rising edge, outputs sampled on the falling edge.
// Tie-break expectations follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_axi_rd_arbiter;

   logic        clk;
   logic        rst;
   logic [31:0] s0_araddr, s1_araddr, m_araddr;
   logic [7:0]  s0_arlen, s1_arlen, m_arlen;
   logic        s0_arvalid, s0_arready, s0_rvalid, s0_rlast;
   logic        s1_arvalid, s1_arready, s1_rvalid, s1_rlast;
   logic [31:0] s_rdata, m_rdata;
   logic [3:0]  m_arid;
   logic [2:0]  m_arsize;
   logic [1:0]  m_arburst;
   logic        m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;

   int n_chk  = 0;
   int n_pass = 0;

   axi_rd_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .s0_araddr  (s0_araddr),
      .s0_arlen   (s0_arlen),
      .s0_arvalid (s0_arvalid),
      .s0_arready (s0_arready),
      .s0_rvalid  (s0_rvalid),
      .s0_rlast   (s0_rlast),
      .s1_araddr  (s1_araddr),
      .s1_arlen   (s1_arlen),
      .s1_arvalid (s1_arvalid),
      .s1_arready (s1_arready),
      .s1_rvalid  (s1_rvalid),
      .s1_rlast   (s1_rlast),
      .s_rdata    (s_rdata),
      .m_arid     (m_arid),
      .m_araddr   (m_araddr),
      .m_arlen    (m_arlen),
      .m_arsize   (m_arsize),
      .m_arburst  (m_arburst),
      .m_arvalid  (m_arvalid),
      .m_arready  (m_arready),
      .m_rdata    (m_rdata),
      .m_rvalid   (m_rvalid),
      .m_rlast    (m_rlast),
      .m_rready   (m_rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   // Caller is at the falling edge where the grant is visible. Completes AR handshake after
   // ar_wait extra cycles, delivers 'beats' beats, then advances to the falling edge after the
   // next possible grant edge.
   task automatic serve(input int ar_wait, input int beats, input logic own,
                        input logic [31:0] addr, input bit hold_req, input bit drop);
      int nb = 0;
      int nx = 0;
      int derr = 0;
      int lastpos = -1;
      tick();
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      if (!hold_req) begin
         if (own) s1_arvalid = 1'b0;
         else     s0_arvalid = 1'b0;
      end
      repeat (ar_wait) tick();
      @(negedge clk);
      chk("ar_held", {31'd0, m_arvalid, m_araddr}, {31'd0, 1'b1, addr});
      tick();
      m_arready = 1'b1;
      tick();
      m_arready = 1'b0;
      @(negedge clk);
      chk("data_entry", {m_arvalid, m_rready}, 2'b01);
      for (int i = 0; i < beats; i++) begin
         tick();
         m_rvalid = 1'b1;
         m_rdata  = $urandom;
         m_rlast  = (i == beats - 1);
         @(negedge clk);
         if (s_rdata !== m_rdata) derr++;
         if (own) begin
            nb += int'(s1_rvalid);
            nx += int'(s0_rvalid) + int'(s0_rlast);
            if (s1_rlast) lastpos = i;
         end else begin
            nb += int'(s0_rvalid);
            nx += int'(s1_rvalid) + int'(s1_rlast);
            if (s0_rlast) lastpos = i;
         end
      end
      tick();
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      if (drop) begin
         s0_arvalid = 1'b0;
         s1_arvalid = 1'b0;
      end
      @(negedge clk);
      chk("bubble", {m_arvalid, m_rready, s0_arready, s1_arready}, 4'b0000);
      chk("beat_count", nb, beats);
      chk("rlast_pos", lastpos, beats - 1);
      chk("other_quiet", nx, 0);
      chk("rdata_bcast", derr, 0);
      tick();
      @(negedge clk);
   endtask

   logic [3:0] exp_id [4];

   initial begin
      rst = 1'b0;
      s0_araddr = '0; s0_arlen = '0; s0_arvalid = 1'b0;
      s1_araddr = '0; s1_arlen = '0; s1_arvalid = 1'b0;
      m_arready = 1'b0; m_rdata = '0; m_rvalid = 1'b0; m_rlast = 1'b0;

      // reset values
      #2;
      chk("rst_ctl", {m_arvalid, s0_arready, s1_arready, m_rready, s0_rvalid, s1_rvalid}, 6'b0);
      chk("rst_addr", m_araddr, 32'h0);
      chk("rst_len_id", {m_arlen, m_arid}, 12'h0);
      chk("ar_attr", {m_arsize, m_arburst}, 5'b010_01);
      tick();
      tick();
      rst = 1'b1;

      // single icache burst of 16 beats
      tick();
      s0_araddr = 32'h1FC0_0040; s0_arlen = 8'd15; s0_arvalid = 1'b1;
      tick();
      @(negedge clk);
      chk("a_grant", {m_arvalid, s0_arready, s1_arready}, 3'b110);
      chk("a_id", m_arid, 4'd0);
      chk("a_addr", m_araddr, 32'h1FC0_0040);
      chk("a_len", m_arlen, 8'd15);
      serve(1, 16, 1'b0, 32'h1FC0_0040, 1'b0, 1'b0);
      chk("a_idle", {m_arvalid, m_rready}, 2'b00);

      // stray R beat while IDLE must be ignored
      tick();
      m_rvalid = 1'b1; m_rlast = 1'b1;
      @(negedge clk);
      chk("idle_rvalid", {s0_rvalid, s1_rvalid, s0_rlast, s1_rlast, m_rready}, 5'b0);
      tick();
      m_rvalid = 1'b0; m_rlast = 1'b0;

      // simultaneous requests: s1 wins (fixed priority, or RR since s0 was granted last)
      s0_araddr = 32'h0000_0100; s0_arlen = 8'd3; s0_arvalid = 1'b1;
      s1_araddr = 32'h0000_0200; s1_arlen = 8'd1; s1_arvalid = 1'b1;
      tick();
      @(negedge clk);
      chk("c_grant", {m_arid, s0_arready, s1_arready}, {4'd1, 2'b01});
      chk("c_addr", {m_araddr, m_arlen}, {32'h0000_0200, 8'd1});
      tick();
      s1_arvalid = 1'b0;
      m_rvalid = 1'b1; m_rlast = 1'b1;
      @(negedge clk);
      chk("addr_rvalid", {s0_rvalid, s1_rvalid, m_rready, s0_arready}, 4'b0);
      serve(0, 2, 1'b1, 32'h0000_0200, 1'b1, 1'b0);
      chk("c_second", {m_arvalid, m_arid, s0_arready}, {1'b1, 4'd0, 1'b1});
      chk("c_addr2", {m_araddr, m_arlen}, {32'h0000_0100, 8'd3});
      serve(0, 4, 1'b0, 32'h0000_0100, 1'b0, 1'b0);

      // both masters request continuously for four bursts
`ifdef ARB_ROUND_ROBIN_EN
      exp_id[0] = 4'd0; exp_id[1] = 4'd1; exp_id[2] = 4'd0; exp_id[3] = 4'd1;
`else
      exp_id[0] = 4'd1; exp_id[1] = 4'd1; exp_id[2] = 4'd1; exp_id[3] = 4'd1;
`endif
      do_reset();
      s0_araddr = 32'h0000_0400; s0_arlen = 8'd1; s0_arvalid = 1'b1;
      s1_araddr = 32'h0000_0800; s1_arlen = 8'd1; s1_arvalid = 1'b1;
      tick();
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("d_id%0d", k), m_arid, exp_id[k]);
         chk($sformatf("d_rdy%0d", k), {s0_arready, s1_arready},
             exp_id[k][0] ? 2'b01 : 2'b10);
         serve(0, 2, exp_id[k][0], exp_id[k][0] ? 32'h0000_0800 : 32'h0000_0400,
               1'b1, k == 3);
      end
      chk("d_no_more", m_arvalid, 1'b0);

      // reset in the middle of an icache burst
      do_reset();
      s0_araddr = 32'h0000_1000; s0_arlen = 8'd15; s0_arvalid = 1'b1;
      tick();
      tick();
      s0_arvalid = 1'b0;
      tick();
      m_arready = 1'b1;
      tick();
      m_arready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         m_rvalid = 1'b1; m_rdata = 32'(i);
      end
      tick();
      m_rvalid = 1'b1;
      @(negedge clk);
      chk("e_beat7", {s0_rvalid, m_rready}, 2'b11);
      #1;
      rst = 1'b0;
      #1;
      chk("e_rst_ctl", {m_arvalid, m_rready, s0_rvalid, s0_rlast, s1_rvalid, s0_arready}, 6'b0);
      chk("e_rst_ar", {m_araddr, m_arlen, m_arid}, 44'h0);
      m_rvalid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      s1_araddr = 32'h0000_3000; s1_arlen = 8'd0; s1_arvalid = 1'b1;
      tick();
      @(negedge clk);
      chk("e_grant", {m_arvalid, m_arid, s1_arready}, {1'b1, 4'd1, 1'b1});
      chk("e_addr", m_araddr, 32'h0000_3000);
      serve(0, 1, 1'b1, 32'h0000_3000, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // guard against a stuck run
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
